// File: rtl/inst_encode.sv
// rtl/inst_encode.sv - RV32I field-bundle encoder with one-deep output register (optional checks: INST_ENCODE_CHECK_EN)
module inst_encode #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_inst,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic              err_sticky,
    output logic [15:0]       inst_cnt
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    logic              out_valid_q,  out_valid_d;
    logic [31:0]       out_inst_q,   out_inst_d;
    logic [ADDR_W-1:0] out_addr_q,   out_addr_d;
    logic              out_err_q,    out_err_d;
    logic              err_sticky_q, err_sticky_d;
    logic [15:0]       inst_cnt_q,   inst_cnt_d;

    logic        accept;
    logic        handoff;
    logic [31:0] enc_inst;
    logic        enc_err;

    // Nothing is accepted during reset; otherwise the output slot must be empty or draining.
    assign in_ready = rst_n && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = rst_n && out_valid_q && out_ready;

    // Assemble the instruction word from the fields the selected format uses.
    always_comb begin
        enc_inst = 32'h0000_0000;
        case (fmt)
            FMT_R: enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U: enc_inst = {imm[31:12], rd, opcode};
            FMT_J: enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc_inst = 32'h0000_0000;
        endcase
    end

`ifdef INST_ENCODE_CHECK_EN
    logic signed [31:0] simm;
    assign simm = imm;

    // Flag fields that cannot be represented in the chosen format.
    always_comb begin
        enc_err = (opcode[1:0] != 2'b11);
        case (fmt)
            FMT_R: ;
            FMT_I, FMT_S:
                if (simm < -32'sd2048 || simm > 32'sd2047) enc_err = 1'b1;
            FMT_B:
                if (imm[0] || simm < -32'sd4096 || simm > 32'sd4094) enc_err = 1'b1;
            FMT_U:
                if (imm[11:0] != 12'h000) enc_err = 1'b1;
            FMT_J:
                if (imm[0] || simm < -32'sd1048576 || simm > 32'sd1048574) enc_err = 1'b1;
            default: enc_err = 1'b1;
        endcase
    end
`else
    assign enc_err = 1'b0;
`endif

    // Retire the held word on handoff, then load a newly accepted word in the same edge.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_addr_d   = out_addr_q;
        out_err_d    = out_err_q;
        err_sticky_d = err_sticky_q;
        inst_cnt_d   = inst_cnt_q;
        if (handoff) begin
            out_valid_d = 1'b0;
            out_addr_d  = out_addr_q + ADDR_W'(1);
            if (inst_cnt_q != 16'hFFFF) inst_cnt_d = inst_cnt_q + 16'd1;
            if (out_err_q) err_sticky_d = 1'b1;
        end
        if (accept) begin
            out_valid_d = 1'b1;
            out_inst_d  = enc_inst;
            out_err_d   = enc_err;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= 32'h0000_0000;
            out_addr_q   <= '0;
            out_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
            inst_cnt_q   <= 16'h0000;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_addr_q   <= out_addr_d;
            out_err_q    <= out_err_d;
            err_sticky_q <= err_sticky_d;
            inst_cnt_q   <= inst_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_inst   = out_inst_q;
    assign out_addr   = out_addr_q;
    assign out_err    = out_err_q;
    assign err_sticky = err_sticky_q;
    assign inst_cnt   = inst_cnt_q;

endmodule

// File: tb/tb_inst_encode.sv
// tb/tb_inst_encode.sv - directed self-checking bench for inst_encode (ADDR_W=2)
module tb_inst_encode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [1:0]  out_addr;
    logic        out_err;
    logic        err_sticky;
    logic [15:0] inst_cnt;

    int checks = 0;
    int fails  = 0;

`ifdef INST_ENCODE_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    inst_encode #(.ADDR_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_sticky(err_sticky),
        .inst_cnt(inst_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        in_valid = 1'b1; fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2;
        funct3 = f3; funct7 = f7; imm = im;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b exp 0", out_valid); end
        checks++; if (out_inst !== 32'h0) begin fails++; $display("FAIL rst_inst got %h exp 0", out_inst); end
        checks++; if (out_addr !== 2'd0) begin fails++; $display("FAIL rst_addr got %0d exp 0", out_addr); end
        checks++; if (out_err !== 1'b0 || err_sticky !== 1'b0) begin fails++; $display("FAIL rst_err got %b%b exp 00", out_err, err_sticky); end
        checks++; if (inst_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", inst_cnt); end
        in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_rst_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_r_format();
        do_reset();
        // imm and funct fields unused by R are driven with junk
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFF);
        tick();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL r_valid got %b exp 1", out_valid); end
        checks++; if (out_inst !== 32'h002081B3) begin fails++; $display("FAIL r_inst got %h exp 002081b3", out_inst); end
        checks++; if (out_addr !== 2'd0) begin fails++; $display("FAIL r_addr got %0d exp 0", out_addr); end
        in_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL r_drain got %b exp 0", out_valid); end
        checks++; if (inst_cnt !== 16'd1) begin fails++; $display("FAIL r_cnt got %0d exp 1", inst_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(3'd1, 7'h13, 5'd2, 5'd1, 5'd31, 3'd0, 7'h7F, 32'h0000_0054);
        tick();
        checks++; if (out_inst !== 32'h05408113 || out_addr !== 2'd0) begin fails++; $display("FAIL b2b_i got %h@%0d exp 05408113@0", out_inst, out_addr); end
        drive(3'd4, 7'h37, 5'd1, 5'd7, 5'd7, 3'd7, 7'h7F, 32'h0002_3000);
        tick();
        checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL b2b_bubble got %b exp 1", out_valid); end
        checks++; if (out_inst !== 32'h000230B7 || out_addr !== 2'd1) begin fails++; $display("FAIL b2b_u got %h@%0d exp 000230b7@1", out_inst, out_addr); end
        in_valid = 1'b0;
        tick();
        checks++; if (inst_cnt !== 16'd2 || out_valid !== 1'b0) begin fails++; $display("FAIL b2b_cnt got %0d/%b exp 2/0", inst_cnt, out_valid); end
    endtask

    task automatic test_branch_jump();
        do_reset();
        drive(3'd3, 7'h63, 5'd9, 5'd2, 5'd1, 3'd1, 7'h55, 32'hFFFF_FFF8);
        tick();
        checks++; if (out_inst !== 32'hFE111CE3) begin fails++; $display("FAIL b_inst got %h exp fe111ce3", out_inst); end
        checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL b_err got %b exp 0", out_err); end
        drive(3'd5, 7'h6F, 5'd4, 5'd3, 5'd3, 3'd5, 7'h11, 32'hFFFF_FFF8);
        tick();
        checks++; if (out_inst !== 32'hFF9FF26F || out_addr !== 2'd1) begin fails++; $display("FAIL j_inst got %h@%0d exp ff9ff26f@1", out_inst, out_addr); end
        drive(3'd2, 7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 7'h00, 32'hFFFF_FFFC);
        tick();
        // S: imm=-4 -> imm[11:5]=7F, imm[4:0]=1C
        checks++; if (out_inst !== 32'hFE62AE23) begin fails++; $display("FAIL s_inst got %h exp fe62ae23", out_inst); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        drive(3'd0, 7'h33, 5'd5, 5'd6, 5'd7, 3'd0, 7'd0, 32'd0);
        tick();
        drive(3'd0, 7'h33, 5'd8, 5'd9, 5'd10, 3'd0, 7'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready cyc %0d got %b exp 0", i, in_ready); end
            checks++; if (out_inst !== 32'h007302B3 || out_addr !== 2'd0 || out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold cyc %0d got %h@%0d v%b exp 007302b3@0 v1", i, out_inst, out_addr, out_valid); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release got %b exp 1", in_ready); end
        tick();
        checks++; if (out_inst !== 32'h00A48433 || out_addr !== 2'd1) begin fails++; $display("FAIL bp_second got %h@%0d exp 00a48433@1", out_inst, out_addr); end
        in_valid = 1'b0;
        tick();
        checks++; if (inst_cnt !== 16'd2 || out_valid !== 1'b0) begin fails++; $display("FAIL bp_cnt got %0d/%b exp 2/0", inst_cnt, out_valid); end
    endtask

    task automatic test_addr_wrap();
        logic [1:0] exp_addr [5];
        exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'd1, 7'h13, 5'(i), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
            tick();
            checks++; if (out_addr !== exp_addr[i] || out_inst[11:7] !== 5'(i)) begin fails++; $display("FAIL wrap_%0d got addr %0d rd %0d exp %0d/%0d", i, out_addr, out_inst[11:7], exp_addr[i], i); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (inst_cnt !== 16'd5) begin fails++; $display("FAIL wrap_cnt got %0d exp 5", inst_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        drive(3'd1, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd1);
        tick();
        drive(3'd1, 7'h13, 5'd2, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2);
        tick();
        checks++; if (out_valid !== 1'b1 || out_addr !== 2'd1) begin fails++; $display("FAIL mr_pre got v%b@%0d exp v1@1", out_valid, out_addr); end
        rst_n = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0 || out_addr !== 2'd0 || inst_cnt !== 16'd0) begin fails++; $display("FAIL mr_clear got v%b@%0d cnt %0d exp v0@0 cnt 0", out_valid, out_addr, inst_cnt); end
        rst_n = 1'b1;
        drive(3'd1, 7'h13, 5'd3, 5'd1, 5'd0, 3'd0, 7'd0, 32'd3);
        tick();
        checks++; if (out_addr !== 2'd0 || out_inst !== 32'h00308193) begin fails++; $display("FAIL mr_first got %h@%0d exp 00308193@0", out_inst, out_addr); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_errors();
        do_reset();
        drive(3'd3, 7'h63, 5'd0, 5'd2, 5'd1, 3'd1, 7'd0, 32'd3);
        tick();
        checks++; if (out_err !== CHK) begin fails++; $display("FAIL err_b_odd got %b exp %b", out_err, CHK); end
        checks++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL err_sticky_early got %b exp 0", err_sticky); end
        drive(3'd6, 7'h33, 5'd1, 5'd1, 5'd1, 3'd1, 7'd1, 32'h1234_5678);
        tick();
        checks++; if (out_inst !== 32'h0 || out_err !== CHK) begin fails++; $display("FAIL err_illegal got %h/%b exp 0/%b", out_inst, out_err, CHK); end
        checks++; if (err_sticky !== CHK) begin fails++; $display("FAIL err_sticky_set got %b exp %b", err_sticky, CHK); end
        drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
        tick();
        checks++; if (out_err !== 1'b0) begin fails++; $display("FAIL err_clean got %b exp 0", out_err); end
        in_valid = 1'b0;
        tick();
        checks++; if (err_sticky !== CHK || inst_cnt !== 16'd3) begin fails++; $display("FAIL err_hold got %b cnt %0d exp %b cnt 3", err_sticky, inst_cnt, CHK); end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
        test_reset();
        test_r_format();
        test_back_to_back();
        test_branch_jump();
        test_backpressure();
        test_addr_wrap();
        test_mid_reset();
        test_errors();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule

// File: doc/inst_encode.md
INST_ENCODE -- requirements
Module: inst_encode

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of the instruction-memory write address.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: field bundle is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: encoder can accept the bundle.
REQ-006 SHALL have port fmt, input, 3 bits: instruction format, 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6-7 illegal.
REQ-007 SHALL have the following field ports, all inputs: opcode 7 bits; rd 5 bits; rs1 5 bits; rs2 5 bits; funct3 3 bits; funct7 7 bits; imm 32 bits, signed byte offset or value.
REQ-008 SHALL have port out_valid, output, 1 bit: encoded word is valid.
REQ-009 SHALL have port out_ready, input, 1 bit: downstream memory writer accepts the word.
REQ-010 SHALL have port out_inst, output, 32 bits: encoded RV32I instruction.
REQ-011 SHALL have port out_addr, output, ADDR_W bits: word address for out_inst.
REQ-012 SHALL have port out_err, output, 1 bit: the current word failed field checks.
REQ-013 SHALL have port err_sticky, output, 1 bit: any error has occurred since reset.
REQ-014 SHALL have port inst_cnt, output, 16 bits: number of words handed off since reset.

Function
REQ-015 SHALL accept a bundle when in_valid and in_ready are both 1.
- in_ready = !out_valid || out_ready.
REQ-016 SHALL present the encoded word with out_valid = 1 on the clock edge after acceptance, giving one-cycle latency.
REQ-017 SHALL keep out_inst, out_addr and out_err stable while out_valid is 1 and out_ready is 0.
REQ-018 SHALL sustain one word per cycle when out_ready is held at 1: a simultaneous handoff and accept replaces the output register in the same edge.
REQ-019 SHALL clear out_valid after a handoff (out_valid and out_ready both 1) if no new bundle is accepted in that cycle.
REQ-020 SHALL encode each format as follows:
- R: {funct7, rs2, rs1, funct3, rd, opcode}
- I: {imm[11:0], rs1, funct3, rd, opcode}
- S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
- U: {imm[31:12], rd, opcode}
- J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
REQ-021 SHALL ignore fields that the selected format does not use.
REQ-022 SHALL encode an illegal fmt as 32'h00000000.
REQ-023 SHALL increment out_addr by 1 on every handoff, wrapping from 2^ADDR_W-1 to 0.
REQ-024 SHALL increment inst_cnt by 1 on every handoff, saturating at 16'hFFFF.
REQ-025 SHALL treat a word whose out_err = 1 like any other word: it is handed off, and out_addr and inst_cnt advance.

Reset
REQ-026 SHALL, on a clock edge with rst_n = 0, set out_valid=0, out_inst=0, out_addr=0, out_err=0, err_sticky=0 and inst_cnt=0.
REQ-027 SHALL hold in_ready at 0 while rst_n = 0.
REQ-028 SHALL discard any pending word on reset mid-operation, with no handoff in the reset cycle.
REQ-029 SHALL make the first bundle accepted after rst_n returns to 1 produce out_addr = 0.

Configuration
REQ-030 SHALL implement field checking when macro INST_ENCODE_CHECK_EN is defined; out_err for a word is 1 if any of these hold:
- fmt is illegal;
- opcode[1:0] != 2'b11;
- I/S imm is outside -2048..2047;
- B imm is odd or outside -4096..4094;
- J imm is odd or outside -1048576..1048574;
- U imm[11:0] != 0.
REQ-031 SHALL, with INST_ENCODE_CHECK_EN defined, set err_sticky on the first handoff with out_err = 1 and hold it until reset.
REQ-032 SHALL, without INST_ENCODE_CHECK_EN, tie out_err and err_sticky to 0, perform no checks and encode all bits as given.

Verification
REQ-033 SHALL cover: R fmt, opcode=0x33, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> out_inst=32'h002081B3 one cycle later, out_addr=0.
REQ-034 SHALL cover: I fmt, opcode=0x13, rd=2, rs1=1, imm=0x54, then U fmt, opcode=0x37, rd=1, imm=0x00023000, back-to-back with out_ready=1 -> 32'h05408113 at addr 0, then 32'h000230B7 at addr 1, no bubble.
REQ-035 SHALL cover: B fmt, opcode=0x63, f3=1, rs1=2, rs2=1, imm=-8 -> 32'hFE111CE3; J fmt, opcode=0x6F, rd=4, imm=-8 -> 32'hFF9FF26F.
REQ-036 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and out_inst and out_addr held; after release, words appear in order with no loss or duplication.
REQ-037 SHALL cover: ADDR_W=2 with 5 handoffs -> out_addr sequence 0,1,2,3,0 and inst_cnt=5; rst_n=0 while out_valid=1 -> out_valid=0 and out_addr=0 on the next edge.
REQ-038 SHALL cover: with INST_ENCODE_CHECK_EN, B fmt imm=3 -> out_err=1 and err_sticky=1 thereafter; without the macro, the same stimulus -> out_err=0.
